// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Desc     : Encodes symbolic instruction records into 32-bit MIPS words and
//            streams them into instruction memory through a small FIFO.
//            Optional: define INSTR_ENCODER_CHECKSUM_EN for a running XOR
//            checksum of every written word.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [15:0]       word_count,
    output logic [31:0]       checksum
);

    localparam int c_ptr_w = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt  = c_cnt_w'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0]  c_addr_step = ADDR_W'(4);

    localparam logic [5:0] c_opc_lw   = 6'b100011;
    localparam logic [5:0] c_opc_sw   = 6'b101011;
    localparam logic [5:0] c_opc_beq  = 6'b000100;
    localparam logic [5:0] c_opc_bne  = 6'b000101;
    localparam logic [5:0] c_opc_xori = 6'b001110;
    localparam logic [5:0] c_opc_addi = 6'b001000;
    localparam logic [5:0] c_opc_j    = 6'b000010;
    localparam logic [5:0] c_opc_jal  = 6'b000011;
    localparam logic [5:0] c_fn_add   = 6'b100000;
    localparam logic [5:0] c_fn_sub   = 6'b100010;
    localparam logic [5:0] c_fn_slt   = 6'b101010;
    localparam logic [5:0] c_fn_jr    = 6'b001000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]         r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_cnt_w-1:0]  r_count;

    logic [ADDR_W-1:0]   r_addr;
    logic [15:0]         r_word_count;
    logic                r_err;

    logic [31:0]         w_word;
    logic                w_legal;
    logic                w_full;
    logic                w_empty;
    logic                w_hs;
    logic                w_push;
    logic                w_pop;
    logic                w_load;

    // ------------------------------------------------------------------------
    // Field encoding; unused fields of each class are forced to zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (in_op)
            4'd0:    w_word = {c_opc_lw,   in_rs, in_rt, in_imm};
            4'd1:    w_word = {c_opc_sw,   in_rs, in_rt, in_imm};
            4'd2:    w_word = {c_opc_j,    in_target};
            4'd3:    w_word = {6'b000000,  in_rs, 15'd0, c_fn_jr};
            4'd4:    w_word = {c_opc_jal,  in_target};
            4'd5:    w_word = {c_opc_beq,  in_rs, in_rt, in_imm};
            4'd6:    w_word = {c_opc_bne,  in_rs, in_rt, in_imm};
            4'd7:    w_word = {c_opc_xori, in_rs, in_rt, in_imm};
            4'd8:    w_word = {c_opc_addi, in_rs, in_rt, in_imm};
            4'd9:    w_word = {6'b000000,  in_rs, in_rt, in_rd, 5'd0, c_fn_add};
            4'd10:   w_word = {6'b000000,  in_rs, in_rt, in_rd, 5'd0, c_fn_sub};
            4'd11:   w_word = {6'b000000,  in_rs, in_rt, in_rd, 5'd0, c_fn_slt};
            default: w_legal = 1'b0;
        endcase
    end

    // Ready depends only on registered state, never on a same-cycle pop.
    assign w_full   = (r_count == c_full_cnt);
    assign w_empty  = (r_count == '0);
    assign in_ready = (r_state == S_RUN) && !w_full;
    assign w_hs     = in_valid && in_ready;
    assign w_push   = w_hs && w_legal;
    assign imem_we  = !w_empty && !reset;
    assign w_pop    = imem_we && mem_ready;
    assign w_load   = (r_state == S_IDLE) && start;

    // ------------------------------------------------------------------------
    // Word FIFO
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign imem_data = r_mem[r_rd_ptr];

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (w_hs && in_last) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                busy = 1'b1;
                if (w_empty) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Write pointer, statistics and sticky error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr       <= BASE_ADDR;
            r_word_count <= '0;
            r_err        <= 1'b0;
        end else if (w_load) begin
            r_addr       <= BASE_ADDR;
            r_word_count <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_pop) begin
                r_addr <= r_addr + c_addr_step;
                if (r_word_count != 16'hFFFF) begin
                    r_word_count <= r_word_count + 16'd1;
                end
            end
            if (w_hs && !w_legal) begin
                r_err <= 1'b1;
            end
        end
    end

    assign imem_addr  = r_addr;
    assign word_count = r_word_count;
    assign err        = r_err;

`ifdef INSTR_ENCODER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset || w_load) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum ^ imem_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Desc     : Self-checking bench for instr_encoder with a queue-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_last, mem_ready;
    logic        in_ready;
    logic [3:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_rd;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we;
    logic [31:0] imem_addr, imem_data;
    logic        busy, done, err;
    logic [15:0] word_count;
    logic [31:0] checksum;

    int          checks = 0;
    int          errors = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [31:0] exp_sum;
    int          exp_count;
    logic        exp_err;
    int          done_seen;
    bit          rnd_mr;

    always #5 clk = ~clk;

    instr_encoder #(
        .ADDR_W    (32),
        .BASE_ADDR (32'h0),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .in_op     (in_op),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_rd     (in_rd),
        .in_imm    (in_imm),
        .in_target (in_target),
        .imem_we   (imem_we),
        .mem_ready (mem_ready),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .word_count(word_count),
        .checksum  (checksum)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference encoding from the instruction-set tables.
    function automatic logic [31:0] ref_enc(input int op, input int rs, input int rt,
                                            input int rd, input int imm, input int tgt);
        int     opcode [12] = '{35, 43, 2, 0, 3, 4, 5, 14, 8, 0, 0, 0};
        int     funct  [12] = '{0, 0, 0, 8, 0, 0, 0, 0, 0, 32, 34, 42};
        longint w;
        if (op == 2 || op == 4)
            w = longint'(opcode[op]) * 64'd67108864 + tgt;
        else if (op == 3)
            w = longint'(rs) * 64'd2097152 + funct[op];
        else if (op >= 9)
            w = longint'(rs) * 64'd2097152 + longint'(rt) * 64'd65536 + rd * 2048 + funct[op];
        else
            w = longint'(opcode[op]) * 64'd67108864 + longint'(rs) * 64'd2097152
                + longint'(rt) * 64'd65536 + imm;
        return w[31:0];
    endfunction

    // One clock: settle, score writes and handshakes, advance to edge+1.
    task automatic cycle(output bit acc);
        int sz0;
        if (rnd_mr) mem_ready = 1'($urandom_range(0, 1));
        #2;
        sz0 = exp_q.size();
        if (in_ready) chk("ready_not_full", 32'(sz0 < DEPTH), 32'd1);
        if (imem_we && mem_ready) begin
            chk("write_expected", 32'(sz0 != 0), 32'd1);
            if (sz0 != 0) begin
                chk("wdata", imem_data, exp_q[0]);
                chk("waddr", imem_addr, exp_addr);
                exp_sum  = exp_sum ^ exp_q[0];
                void'(exp_q.pop_front());
                exp_addr = exp_addr + 32'd4;
                if (exp_count < 65535) exp_count++;
            end
        end
        acc = in_valid && in_ready;
        if (acc) begin
            if (in_op < 4'd12)
                exp_q.push_back(ref_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                                        int'(in_imm), int'(in_target)));
            else
                exp_err = 1'b1;
        end
        if (done) done_seen++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bit acc;
        start = 1'b1;
        cycle(acc);
        start     = 1'b0;
        exp_q.delete();
        exp_addr  = 32'h0;
        exp_sum   = 32'h0;
        exp_count = 0;
        exp_err   = 1'b0;
        done_seen = 0;
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd,
                        input int imm, input int tgt, input bit last);
        bit acc;
        int n;
        in_valid  = 1'b1;
        in_op     = 4'(op);
        in_rs     = 5'(rs);
        in_rt     = 5'(rt);
        in_rd     = 5'(rd);
        in_imm    = 16'(imm);
        in_target = 26'(tgt);
        in_last   = last;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 300) begin
            cycle(acc);
            n++;
        end
        if (!acc) chk("send_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_load();
        bit acc;
        int n = 0;
        while (done_seen == 0 && n < 600) begin
            cycle(acc);
            n++;
        end
        chk("done_pulse", 32'(done_seen), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("word_count", 32'(word_count), 32'(exp_count));
        chk("err", 32'(err), 32'(exp_err));
        chk("busy_after_done", 32'(busy), 32'd0);
`ifdef INSTR_ENCODER_CHECKSUM_EN
        chk("checksum", checksum, exp_sum);
`else
        chk("checksum_tied", checksum, 32'h0);
`endif
    endtask

    initial begin
        bit acc;
        int len, r, op;
        logic [31:0] head;

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ready = 1'b0;
        in_op = '0; in_rs = '0; in_rt = '0; in_rd = '0; in_imm = '0; in_target = '0;
        rnd_mr = 1'b0;
        exp_addr = 0; exp_sum = 0; exp_count = 0; exp_err = 0; done_seen = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(word_count), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_checksum", checksum, 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Single ADD, one-cycle latency to the write port.
        mem_ready = 1'b1;
        start = 1'b1;
        #2;
        chk("start_cycle_ready", 32'(in_ready), 32'd0);
        #(-0);
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.delete(); exp_addr = 0; exp_sum = 0; exp_count = 0; exp_err = 0; done_seen = 0;
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_ready", 32'(in_ready), 32'd1);
        send(9, 1, 2, 3, 0, 0, 1'b1);
        chk("add_we", 32'(imem_we), 32'd1);
        chk("add_word", imem_data, 32'h00221820);
        finish_load();

        // LW / J / JR sequence.
        do_start();
        send(0, 29, 8, 0, 4, 0, 1'b0);
        send(2, 0, 0, 0, 0, 32'h10, 1'b0);
        send(3, 31, 0, 0, 0, 0, 1'b1);
        finish_load();
        chk("seq_count", 32'(word_count), 32'd3);

        // Backpressure: FIFO fills, data holds, then all six drain in order.
        do_start();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(8, i, i + 1, 0, 16'h100 + i, 0, 1'b0);
        head = exp_q[0];
        in_valid = 1'b1; in_op = 4'd9; in_rs = 5'd4; in_rt = 5'd5; in_rd = 5'd6;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("full_ready_low", 32'(in_ready), 32'd0);
            chk("hold_data", imem_data, head);
            chk("hold_addr", imem_addr, 32'h0);
            @(posedge clk);
            #1;
        end
        mem_ready = 1'b1;
        send(9, 4, 5, 6, 0, 0, 1'b0);
        send(10, 7, 8, 9, 0, 0, 1'b1);
        finish_load();
        chk("bp_count", 32'(word_count), 32'd6);

        // Illegal op in the middle of a program.
        do_start();
        send(5, 1, 0, 0, 16'hFFFF, 0, 1'b0);
        send(13, 2, 2, 2, 2, 2, 1'b0);
        send(6, 1, 0, 0, 16'h0003, 0, 1'b1);
        finish_load();
        chk("illegal_err", 32'(err), 32'd1);
        chk("illegal_count", 32'(word_count), 32'd2);

        // Reset with buffered words.
        do_start();
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(7, i, i, 0, i, 0, 1'b0);
        reset = 1'b1;
        #2;
        chk("reset_cycle_we", 32'(imem_we), 32'd0);
        @(posedge clk);
        #1;
        chk("post_rst_we", 32'(imem_we), 32'd0);
        chk("post_rst_addr", imem_addr, 32'h0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        exp_q.delete();
        mem_ready = 1'b1;
        do_start();
        send(0, 29, 8, 0, 4, 0, 1'b1);
        finish_load();

        // Randomized programs with random gaps and backpressure.
        rnd_mr = 1'b1;
        for (int p = 0; p < 4; p++) begin
            do_start();
            len = $urandom_range(5, 20);
            for (int k = 0; k < len; k++) begin
                repeat ($urandom_range(0, 2)) cycle(acc);
                r  = $urandom_range(0, 19);
                op = (r < 12) ? r : ((r < 18) ? $urandom_range(0, 11) : $urandom_range(12, 15));
                send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 65535), $urandom_range(0, 32'h3FFFFFF), k == len - 1);
            end
            finish_load();
        end
        rnd_mr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
